// File: rtl/money_manager.sv
// rtl/money_manager.sv - coin-operated balance keeper with buy/refund handling and an error-hold LED
module money_manager #(
    parameter int MAX_MONEY  = 10000,
    parameter int ERR_CYCLES = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_c100,
    input  logic        btn_c500,
    input  logic        btn_c1000,
    input  logic        buy_req,
    input  logic [15:0] price,
    input  logic        refund_req,
    output logic [15:0] current_money,
    output logic        buy_ok,
    output logic        buy_fail,
    output logic        sat_flag,
    output logic [15:0] change_out,
    output logic        err_led
);

    localparam int              CW       = (ERR_CYCLES > 1) ? $clog2(ERR_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_LOAD = CW'(ERR_CYCLES - 1);
    localparam logic [16:0]     MAX17    = 17'(MAX_MONEY);

    typedef enum logic {IDLE = 1'b0, ERR = 1'b1} state_t;

    state_t      state_q;
    logic [CW-1:0] cnt_q;
    logic        run_q;
    logic [1:0]  fill_q;
    logic [2:0]  btn_raw, sync1_q, sync2_q, prev_q, arm_q, coin_q, rise;
    logic [15:0] money_q, money_d, change_q, change_d;
    logic        buy_ok_q, buy_ok_d, buy_fail_q, buy_fail_d, sat_q, sat_d, err_q;
    logic [16:0] money17, price17, coin_val, coin_sum;

    assign btn_raw = {btn_c1000, btn_c500, btn_c100};
    // A button only arms after the synchronizer has shown a real low, so a press held through reset is ignored.
    assign rise    = sync2_q & ~prev_q & arm_q;

    always_comb begin
        money17  = {1'b0, money_q};
        price17  = {1'b0, price};
        coin_val = 17'd0;
        if (coin_q[2])      coin_val = 17'd1000;
        else if (coin_q[1]) coin_val = 17'd500;
        else if (coin_q[0]) coin_val = 17'd100;
        coin_sum   = money17 + coin_val;
        money_d    = money_q;
        change_d   = change_q;
        buy_ok_d   = 1'b0;
        buy_fail_d = 1'b0;
        sat_d      = 1'b0;
        if (refund_req) begin
            change_d = money_q;
            money_d  = 16'd0;
        end else if (buy_req) begin
            if (price != 16'd0 && price17 <= money17) begin
                money_d  = 16'(money17 - price17);
                buy_ok_d = 1'b1;
            end else begin
                buy_fail_d = 1'b1;
            end
        end else if (coin_val != 17'd0) begin
            if (coin_sum > MAX17) begin
                money_d = MAX17[15:0];
                sat_d   = 1'b1;
            end else begin
                money_d = coin_sum[15:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q      <= 1'b0;
            fill_q     <= 2'b00;
            sync1_q    <= 3'b000;
            sync2_q    <= 3'b000;
            prev_q     <= 3'b000;
            arm_q      <= 3'b000;
            coin_q     <= 3'b000;
            money_q    <= 16'd0;
            change_q   <= 16'd0;
            buy_ok_q   <= 1'b0;
            buy_fail_q <= 1'b0;
            sat_q      <= 1'b0;
            err_q      <= 1'b0;
            state_q    <= IDLE;
            cnt_q      <= '0;
        end else begin
            run_q <= 1'b1;
            // The edge that first sees rst low only arms run_q; functional updates start one edge later.
            if (run_q) begin
                fill_q     <= {fill_q[0], 1'b1};
                sync1_q    <= btn_raw;
                sync2_q    <= sync1_q;
                prev_q     <= sync2_q;
                arm_q      <= arm_q | (~sync2_q & {3{fill_q[1]}});
                coin_q     <= rise;
                money_q    <= money_d;
                change_q   <= change_d;
                buy_ok_q   <= buy_ok_d;
                buy_fail_q <= buy_fail_d;
                sat_q      <= sat_d;
                case (state_q)
                    IDLE: begin
                        err_q <= 1'b0;
                        if (buy_fail_d) begin
                            state_q <= ERR;
                            cnt_q   <= CNT_LOAD;
                            err_q   <= 1'b1;
                        end
                    end
                    ERR: begin
                        if (buy_fail_d) begin
                            cnt_q <= CNT_LOAD;
                        end else if (cnt_q == '0) begin
                            state_q <= IDLE;
                            err_q   <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                endcase
            end
        end
    end

    assign current_money = money_q;
    assign change_out    = change_q;
    assign buy_ok        = buy_ok_q;
    assign buy_fail      = buy_fail_q;
    assign sat_flag      = sat_q;
    assign err_led       = err_q;

endmodule

// File: doc/money_manager.md
MONEY_MANAGER -- requirements
Module: money_manager

Interface
REQ-001 Parameter MAX_MONEY, 10000, saturation ceiling for the balance.
REQ-002 Parameter ERR_CYCLES, 50000000, err_led hold time in clk cycles (0.5 s at 100 MHz).
REQ-003 clk  input  1  system clock, 100 MHz.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 btn_c100  input  1  raw asynchronous push button; each press adds 100.
REQ-006 btn_c500  input  1  raw asynchronous push button; each press adds 500.
REQ-007 btn_c1000  input  1  raw asynchronous push button; each press adds 1000.
REQ-008 buy_req  input  1  synchronous one-cycle purchase request.
REQ-009 price  input  16  purchase price, sampled when buy_req=1.
REQ-010 refund_req  input  1  synchronous one-cycle request to return the whole balance.
REQ-011 current_money  output  16  registered balance, 0..MAX_MONEY, feeds the 7-seg display stage.
REQ-012 buy_ok  output  1  one-cycle pulse on a successful purchase.
REQ-013 buy_fail  output  1  one-cycle pulse on a rejected purchase.
REQ-014 sat_flag  output  1  one-cycle pulse when a coin add was clamped.
REQ-015 change_out  output  16  balance returned by the last refund, held until the next refund.
REQ-016 err_led  output  1  high while the ERR state holds.

Function
REQ-017 Each btn_* SHALL pass through a 2-FF synchronizer and then a rising-edge detector; a held button SHALL count once.
REQ-018 Coin latency: current_money SHALL show the new value 3 clk edges after the first edge that samples the button high.
REQ-019 Coin add: new = money + value; if new > MAX_MONEY, store MAX_MONEY and pulse sat_flag in the same cycle.
REQ-020 Only one coin edge SHALL be applied per cycle; simultaneous edges SHALL use priority c1000 > c500 > c100; the lower-priority edges are dropped.
REQ-021 Buy: if price != 0 and price <= current_money, subtract price and pulse buy_ok on the next edge; otherwise leave the balance unchanged, pulse buy_fail and enter ERR.
REQ-022 Refund: change_out <= current_money and current_money <= 0 on the next edge.
REQ-023 A refund at balance 0 SHALL set change_out to 0.
REQ-024 Same-cycle priority SHALL be refund > buy > coin; a lower-priority event in that cycle is discarded, and its pulse outputs stay low.
REQ-025 FSM state IDLE SHALL keep err_led=0 and take the buy_fail transition to ERR.
REQ-026 FSM state ERR SHALL load the counter with ERR_CYCLES-1, assert err_led, decrement each cycle, and return to IDLE after the cycle in which the counter = 0.
REQ-027 A buy_fail while in ERR SHALL reload the counter.
REQ-028 Coins, buys and refunds SHALL be processed normally in ERR.
REQ-029 All arithmetic SHALL use 17-bit intermediates so that no wrap-around occurs.
REQ-030 current_money SHALL never exceed MAX_MONEY and never underflow.
REQ-031 All outputs SHALL be registered.

Reset
REQ-032 While rst=1, regardless of clk: current_money=0, change_out=0, buy_ok=0, buy_fail=0, sat_flag=0, err_led=0, FSM=IDLE, counter=0, synchronizer and edge registers=0.
REQ-033 Reset mid-operation (ERR, pending edge) SHALL abort all activity; a button still held at release SHALL NOT generate a press until it is released and pressed again.
REQ-034 Reset release SHALL be taken synchronously; the first functional edge is the first clk edge after the edge on which rst is seen low.

Verification
REQ-035 Press c1000 three times, then c500 once -> current_money 3500; each update appears 3 cycles after its press; sat_flag stays 0.
REQ-036 Balance 9800, press c500 -> current_money 10000 and a one-cycle sat_flag pulse; press c100 -> 10000 and sat_flag pulses again.
REQ-037 Balance 3500: buy_req with price 1200 -> 2300 and buy_ok pulse; buy_req with price 5000 -> stays 2300, buy_fail pulse, err_led high for exactly ERR_CYCLES cycles (ERR_CYCLES=10 in sim).
REQ-038 Balance 2300: refund_req, buy_req with price 100 and a c100 edge in the same cycle -> change_out 2300, current_money 0, buy_ok=0, buy_fail=0.
REQ-039 Hold btn_c500 high for 1000 cycles -> exactly one +500; glitch the button for 1 cycle -> at most one +500.
REQ-040 Assert rst during ERR with balance 4000 -> all outputs return to their reset values immediately; after release, err_led=0 and current_money=0.
